data_mem_ctrl: RTL and testbench

- Parametrised successor to the 32-bit instruction memory: a single-port data memory for the ARM32 load/store stage.
- Adds a valid/ready request handshake and programmable wait states.
- Adds byte/halfword/word access with little-endian lane steering, sign or zero extension on loads, and misalignment error reporting.
- Sits between the MEM pipeline stage and on-chip RAM; the core stalls while req_ready is low.

---
 rtl/mem_pkg.sv | 65 ++++++
 rtl/data_mem_ctrl_if.sv | 26 ++
 rtl/sram_1rw_be.sv | 28 ++
 rtl/data_mem_ctrl.sv | 126 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the data memory controller.
// Covers access sizes, FSM states, alignment checks, byte enables and load extraction.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = WORD_W / 8;
    localparam int unsigned WAIT_W = 4;

    // Size 2'b11 is reserved and never legal.
    function automatic logic access_ok(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~a[0];
            SZ_WORD: return (a == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [LANES-1:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 4'b0001 << a;
            SZ_HALF: return 4'b0011 << a;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] store_lanes(input logic [1:0] size,
                                                      input logic [WORD_W-1:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] load_extract(input logic [1:0]        size,
                                                       input logic              sgn,
                                                       input logic [1:0]        a,
                                                       input logic [WORD_W-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*a +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return {{24{sgn & b[7]}}, b};
            SZ_HALF: return {{16{sgn & h[15]}}, h};
            SZ_WORD: return word;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory controller (slave).
interface data_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/sram_1rw_be.sv
// Single-port RAM with synchronous byte-enable write and asynchronous read.
module sram_1rw_be #(
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing thousands of words is not a RAM
    // operation, and software never relies on power-up contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller for the ARM32 load/store stage: valid/ready requests,
// programmable wait states, byte/half/word little-endian accesses with error reporting.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    if (DATA_W != WORD_W) begin : g_bad_data_w
        $error("data_mem_ctrl: DATA_W must be 32");
    end
    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("data_mem_ctrl: WAIT_CYCLES must be 0..15");
    end

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q;
    logic                we_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic                accept;
    logic                complete;
    logic                ready;
    logic                valid;
    logic                ok;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_rdata;

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        ready    = 1'b0;
        valid    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    complete = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                valid   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ok     = access_ok(size_q, addr_q[1:0]);
    assign ram_we = complete & we_q & ok;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= bus.req_we;
                size_q   <= bus.req_size;
                signed_q <= bus.req_signed;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                cnt_q    <= WAIT_INIT;
            end else if (state_q == ST_BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            // Response data stays put until the next completion overwrites it.
            if (complete) begin
                err_q   <= ~ok;
                rdata_q <= (ok && !we_q) ? load_extract(size_q, signed_q, addr_q[1:0], ram_rdata)
                                         : '0;
            end
        end
    end

    sram_1rw_be #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (byte_en(size_q, addr_q[1:0])),
        .addr  (addr_q[ADDR_W-1:2]),
        .wdata (store_lanes(size_q, wdata_q)),
        .rdata (ram_rdata)
    );

    assign bus.req_ready  = ready;
    assign bus.resp_valid = valid;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: zero-wait and three-wait instances
// against a byte-addressed reference memory.
module tb_data_mem_ctrl;
    import mem_pkg::*;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int MEM_B  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n0;
    logic rst_n3;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
    data_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();

    data_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n0),
        .bus   (bus0)
    );
    data_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n3),
        .bus   (bus3)
    );

    int n_checks = 0;
    int n_fails  = 0;
    logic [7:0] model [2][MEM_B];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int wait_of(input int sel);
        return (sel == 0) ? 0 : 3;
    endfunction

    function automatic bit legal(input logic [1:0] size, input logic [12:0] addr);
        if (size == 2'b11) return 1'b0;
        return (int'(addr) % (1 << size)) == 0;
    endfunction

    function automatic logic [31:0] model_load(input int sel, input logic [1:0] size,
                                               input logic sgn, input logic [12:0] addr);
        logic [31:0] v;
        int n;
        v = '0;
        n = 1 << size;
        for (int i = 0; i < n; i++) v = v | (32'(model[sel][int'(addr) + i]) << (8 * i));
        if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input int sel, input logic [1:0] size,
                               input logic [12:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < (1 << size); i++) model[sel][int'(addr) + i] = wdata[8*i +: 8];
    endtask

    task automatic set_req(input int sel, input logic v, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [12:0] addr, input logic [31:0] wdata);
        if (sel == 0) begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_size = size;
            bus0.req_signed = sgn; bus0.req_addr = addr; bus0.req_wdata = wdata;
        end else begin
            bus3.req_valid = v; bus3.req_we = we; bus3.req_size = size;
            bus3.req_signed = sgn; bus3.req_addr = addr; bus3.req_wdata = wdata;
        end
    endtask

    task automatic get_resp(input int sel, output logic rdy, output logic vld,
                            output logic [31:0] rd, output logic er);
        if (sel == 0) begin
            rdy = bus0.req_ready; vld = bus0.resp_valid; rd = bus0.resp_rdata; er = bus0.resp_err;
        end else begin
            rdy = bus3.req_ready; vld = bus3.resp_valid; rd = bus3.resp_rdata; er = bus3.resp_err;
        end
    endtask

    task automatic set_rst(input int sel, input logic v);
        if (sel == 0) rst_n0 = v;
        else          rst_n3 = v;
    endtask

    task automatic check_reset_outputs(input int sel, input string tag);
        logic rdy, vld, er;
        logic [31:0] rd;
        get_resp(sel, rdy, vld, rd, er);
        check1({tag, "_ready"}, rdy, 1'b1);
        check1({tag, "_valid"}, vld, 1'b0);
        check({tag, "_rdata"}, rd, 32'h0);
        check1({tag, "_err"}, er, 1'b0);
    endtask

    // One full transaction with latency, pulse-width and result checks.
    task automatic xact(input int sel, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [12:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
        int          edges;
        int          low;
        bit          seen;
        bit          ok;
        logic        rdy, vld, er2;
        logic [31:0] exp_d, rd2;
        edges = 0;
        low   = 0;
        seen  = 1'b0;
        ok    = legal(size, addr);
        exp_d = (ok && !we) ? model_load(sel, size, sgn, addr) : 32'h0;
        @(negedge clk);
        set_req(sel, 1'b1, we, size, sgn, addr, wdata);
        get_resp(sel, rdy, vld, rdata, err);
        check1("ready_idle", rdy, 1'b1);
        @(posedge clk);
        #1;
        set_req(sel, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                13'($urandom), $urandom);
        @(negedge clk);
        get_resp(sel, rdy, vld, rdata, err);
        if (!rdy) low++;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            get_resp(sel, rdy, vld, rdata, err);
            if (!rdy) low++;
            if (vld) seen = 1'b1;
        end
        set_req(sel, 1'b0, 1'b0, 2'b00, 1'b0, 13'h0, 32'h0);
        check1("resp_seen", seen, 1'b1);
        check("latency", 32'(edges), 32'(wait_of(sel) + 1));
        check("ready_low", 32'(low), 32'(wait_of(sel) + 2));
        check("rdata", rdata, exp_d);
        check1("err", err, !ok);
        if (ok && we) model_store(sel, size, addr, wdata);
        @(posedge clk);
        @(negedge clk);
        get_resp(sel, rdy, vld, rd2, er2);
        check1("valid_pulse", vld, 1'b0);
        check1("ready_back", rdy, 1'b1);
        check("rdata_hold", rd2, exp_d);
        check1("err_hold", er2, !ok);
    endtask

    // Word store interrupted by reset n_edges after the accept edge.
    task automatic abort_store(input int sel, input logic [12:0] addr, input logic [31:0] wdata,
                               input int n_edges);
        logic rdy, vld, er;
        logic [31:0] rd;
        @(negedge clk);
        set_req(sel, 1'b1, 1'b1, SZ_WORD, 1'b0, addr, wdata);
        @(posedge clk);
        #1;
        set_req(sel, 1'b0, 1'b0, 2'b00, 1'b0, 13'h0, 32'h0);
        repeat (n_edges) @(posedge clk);
        #2;
        get_resp(sel, rdy, vld, rd, er);
        check1("pre_rst_valid", vld, (n_edges >= wait_of(sel) + 1) ? 1'b1 : 1'b0);
        set_rst(sel, 1'b0);
        #1;
        check_reset_outputs(sel, "async_rst");
        if (n_edges >= wait_of(sel) + 1) model_store(sel, SZ_WORD, addr, wdata);
        repeat (2) @(posedge clk);
        @(negedge clk);
        set_rst(sel, 1'b1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        rst_n0 = 1'b0;
        rst_n3 = 1'b0;
        set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 13'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 13'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n0 = 1'b1;
        rst_n3 = 1'b1;
        @(negedge clk);
        check_reset_outputs(0, "reset0");
        check_reset_outputs(1, "reset3");

        for (int a = 0; a < 256; a += 4) xact(0, 1'b1, SZ_WORD, 1'b0, 13'(a), 32'h0, r, e);

        xact(0, 1'b1, SZ_WORD, 1'b0, 13'h010, 32'hDEAD_BEEF, r, e);
        xact(0, 1'b0, SZ_WORD, 1'b0, 13'h010, 32'h0, r, e);
        check("ld_word_deadbeef", r, 32'hDEAD_BEEF);
        check1("ld_word_err", e, 1'b0);

        xact(0, 1'b1, SZ_BYTE, 1'b0, 13'h013, 32'h5A5A_5A80, r, e);
        xact(0, 1'b0, SZ_BYTE, 1'b1, 13'h013, 32'h0, r, e);
        check("ld_byte_signed", r, 32'hFFFF_FF80);
        xact(0, 1'b0, SZ_BYTE, 1'b0, 13'h013, 32'h0, r, e);
        check("ld_byte_unsigned", r, 32'h0000_0080);
        xact(0, 1'b0, SZ_WORD, 1'b1, 13'h010, 32'h0, r, e);
        check("ld_word_merged", r, 32'h80AD_BEEF);

        xact(0, 1'b1, SZ_HALF, 1'b0, 13'h020, 32'hA5A5_8001, r, e);
        xact(0, 1'b0, SZ_HALF, 1'b1, 13'h020, 32'h0, r, e);
        check("ld_half_signed", r, 32'hFFFF_8001);
        xact(0, 1'b0, SZ_HALF, 1'b0, 13'h022, 32'h0, r, e);
        check("ld_half_upper", r, 32'h0000_0000);

        xact(0, 1'b1, SZ_WORD, 1'b0, 13'h021, 32'hFFFF_FFFF, r, e);
        check1("misaligned_err", e, 1'b1);
        check("misaligned_rdata", r, 32'h0);
        xact(0, 1'b0, 2'b11, 1'b0, 13'h020, 32'h0, r, e);
        check1("reserved_err", e, 1'b1);
        check("reserved_rdata", r, 32'h0);
        xact(0, 1'b0, SZ_WORD, 1'b0, 13'h020, 32'h0, r, e);
        check("word_unchanged", r, 32'h0000_8001);

        for (int i = 0; i < 150; i++)
            xact(0, 1'($urandom), 2'($urandom), 1'($urandom), 13'($urandom_range(0, 255)),
                 $urandom, r, e);

        abort_store(0, 13'h030, 32'h1122_3344, 0);
        xact(0, 1'b0, SZ_WORD, 1'b0, 13'h030, 32'h0, r, e);
        abort_store(0, 13'h034, 32'h5566_7788, 1);
        xact(0, 1'b0, SZ_WORD, 1'b0, 13'h034, 32'h0, r, e);
        check("resp_rst_committed", r, 32'h5566_7788);

        for (int a = 'h40; a < 'h50; a += 4) xact(1, 1'b1, SZ_WORD, 1'b0, 13'(a), 32'h0, r, e);
        xact(1, 1'b1, SZ_WORD, 1'b0, 13'h040, 32'hCAFE_F00D, r, e);
        xact(1, 1'b0, SZ_WORD, 1'b0, 13'h040, 32'h0, r, e);
        check("w3_ld_word", r, 32'hCAFE_F00D);
        abort_store(1, 13'h040, 32'h1234_5678, 2);
        xact(1, 1'b0, SZ_WORD, 1'b0, 13'h040, 32'h0, r, e);
        check("w3_aborted_store", r, 32'hCAFE_F00D);
        for (int i = 0; i < 12; i++)
            xact(1, 1'($urandom), 2'($urandom), 1'($urandom), 13'($urandom_range('h40, 'h4F)),
                 $urandom, r, e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
